// File: rtl/lane_permute_ctrl_if.sv
// Memory-side bundle of the lane permutation sequencer: read port with one-cycle
// latency plus a write port with a ready/stall handshake.
interface lane_permute_ctrl_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 6
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, wr_ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, wr_ready
  );
endinterface

// File: rtl/lane_permute_ctrl.sv
// Lane permutation sequencer: moves lane (x,y) of a DIM x DIM state to (y, CA*x+CB*y mod DIM),
// ping-ponging between two memory banks for a runtime number of rounds.
module lane_permute_ctrl #(
  parameter int unsigned DIM = 5,
  parameter int unsigned DW  = 64,
  parameter int unsigned CW  = 3,
  parameter int unsigned RW  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         coef_a,
  input  logic [CW-1:0]         coef_b,
  input  logic [RW-1:0]         num_rounds,
  lane_permute_ctrl_if.master   mem,
  output logic                  busy,
  output logic                  done,
  output logic                  res_bank
);

  localparam int unsigned NL   = DIM * DIM;
  localparam int unsigned AW   = $clog2(2 * NL);
  localparam int unsigned XW   = $clog2(DIM);
  localparam int unsigned SMAX = 2 * ((1 << CW) - 1) * (DIM - 1);
  localparam int unsigned SW   = $clog2(SMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_CAPTURE, S_REDUCE, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [XW-1:0]   x, y;
  logic [RW-1:0]   round, last_round;
  logic            bank;
  logic [SW-1:0]   sum;
  logic [CW-1:0]   ca, cb;
  logic [DW-1:0]   wr_data_q;
  logic            last_lane;
  logic            is_last_round;
  logic [AW-1:0]   rd_addr_calc;
  logic [AW-1:0]   wr_addr_calc;

  assign last_lane     = (x == XW'(DIM - 1)) && (y == XW'(DIM - 1));
  assign is_last_round = (round == last_round);
  assign rd_addr_calc  = (bank ? AW'(NL) : AW'(0)) + AW'(y) * AW'(DIM) + AW'(x);
  // Destination lane is (y, sum): row index comes from the reduced sum.
  assign wr_addr_calc  = (bank ? AW'(0) : AW'(NL)) + AW'(sum) * AW'(DIM) + AW'(y);
  assign mem.wr_data   = wr_data_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_n     = state;
    mem.rd_en   = 1'b0;
    mem.rd_addr = '0;
    mem.wr_en   = 1'b0;
    mem.wr_addr = '0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_LOAD;
      end
      S_LOAD:    state_n = S_READ;
      S_READ: begin
        mem.rd_en   = 1'b1;
        mem.rd_addr = rd_addr_calc;
        state_n     = S_CAPTURE;
      end
      S_CAPTURE: state_n = S_REDUCE;
      S_REDUCE:  if (sum < SW'(DIM)) state_n = S_WRITE;
      S_WRITE: begin
        mem.wr_en   = 1'b1;
        mem.wr_addr = wr_addr_calc;
        if (mem.wr_ready) state_n = S_NEXT;
      end
      S_NEXT:    state_n = (last_lane && is_last_round) ? S_DONE : S_READ;
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath: coefficients, lane indices, round/bank tracking and the modular sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x          <= '0;
      y          <= '0;
      round      <= '0;
      last_round <= '0;
      bank       <= 1'b0;
      sum        <= '0;
      ca         <= '0;
      cb         <= '0;
      wr_data_q  <= '0;
      res_bank   <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          ca         <= coef_a;
          cb         <= coef_b;
          last_round <= (num_rounds == '0) ? '0 : num_rounds - RW'(1);
          x          <= '0;
          y          <= '0;
          round      <= '0;
          bank       <= 1'b0;
          res_bank   <= 1'b0;
        end
        S_CAPTURE: begin
          wr_data_q <= mem.rd_data;
          sum       <= SW'(ca) * SW'(x) + SW'(cb) * SW'(y);
        end
        S_REDUCE: begin
          if (sum >= SW'(DIM)) sum <= sum - SW'(DIM);
        end
        S_NEXT: begin
          if (!last_lane) begin
            if (x == XW'(DIM - 1)) begin
              x <= '0;
              y <= y + XW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end else if (!is_last_round) begin
            round <= round + RW'(1);
            bank  <= ~bank;
            x     <= '0;
            y     <= '0;
          end else begin
            bank     <= ~bank;
            res_bank <= ~bank;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_permute_ctrl.sv
// Randomised self-checking bench for lane_permute_ctrl against an array-based
// permutation model with a behavioural two-bank memory.
module tb_lane_permute_ctrl;

  localparam int unsigned DIM    = 5;
  localparam int unsigned DW     = 64;
  localparam int unsigned CW     = 3;
  localparam int unsigned RW     = 5;
  localparam int unsigned NL     = DIM * DIM;
  localparam int unsigned AW     = $clog2(2 * NL);
  localparam int          BUDGET = 6000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] coef_a = '0;
  logic [CW-1:0] coef_b = '0;
  logic [RW-1:0] num_rounds = '0;
  logic          busy, done, res_bank;

  lane_permute_ctrl_if #(.DW(DW), .AW(AW)) mif ();

  lane_permute_ctrl #(.DIM(DIM), .DW(DW), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .coef_a(coef_a), .coef_b(coef_b),
    .num_rounds(num_rounds), .mem(mif), .busy(busy), .done(done), .res_bank(res_bank)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem      [2*NL];
  logic [DW-1:0] init_val [2*NL];
  logic [DW-1:0] ref_mem  [2*NL];
  logic          init_req = 1'b0;

  // Behavioural memory: registered read, write on handshake
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 2*NL; i++) mem[i] <= init_val[i];
    end else begin
      if (mif.rd_en && (int'(mif.rd_addr) < 2*NL)) mif.rd_data <= mem[mif.rd_addr];
      if (mif.wr_en && mif.wr_ready && (int'(mif.wr_addr) < 2*NL)) mem[mif.wr_addr] <= mif.wr_data;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_rd[$], exp_wr[$], exp_k[$];
  int lat_q[$], lst_q[$], wr_log[$];
  int busy_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 2*NL; i++) begin
      init_val[i] = {$urandom, $urandom};
      ref_mem[i]  = init_val[i];
    end
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Reference: apply the lane mapping r times, alternating source bank
  task automatic build_model(input int ca, input int cb, input int r);
    exp_rd.delete(); exp_wr.delete(); exp_k.delete();
    for (int rr = 0; rr < r; rr++) begin
      int b = rr % 2;
      for (int yy = 0; yy < DIM; yy++) begin
        for (int xx = 0; xx < DIM; xx++) begin
          int s  = ca * xx + cb * yy;
          int ra = b * NL + yy * DIM + xx;
          int wa = (1 - b) * NL + (s % DIM) * DIM + yy;
          exp_rd.push_back(ra);
          exp_wr.push_back(wa);
          exp_k.push_back(s / DIM);
          ref_mem[wa] = ref_mem[ra];
        end
      end
    end
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = three stall cycles per write
  task automatic run_op(input int ca, input int cb, input int nr, input int mode, input bit poke);
    int reff = (nr == 0) ? 1 : nr;
    int cyc = 0, rd_i = 0, wr_i = 0, stalls = 0, lane_stalls = 0, stall_run = 0;
    int prev_rd_cyc = 0, done_cnt = 0, overlap = 0, extra = 0, ksum = 0;
    bit seen_done = 0, prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    load_mem();
    build_model(ca, cb, reff);
    lat_q.delete(); lst_q.delete(); wr_log.delete();
    busy_cnt = 0;
    coef_a = CW'(ca); coef_b = CW'(cb); num_rounds = RW'(nr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && cyc < BUDGET) begin
      if (mode == 1)      mif.wr_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) mif.wr_ready = (stall_run >= 3);
      else                mif.wr_ready = 1'b1;
      if (busy) busy_cnt++;
      if (mif.rd_en && mif.wr_en) overlap++;
      if (prev_stall) begin
        check_eq("stall_wr_en", 64'(mif.wr_en), 64'(1));
        check_eq("stall_wr_addr", 64'(mif.wr_addr), 64'(prev_addr));
        check_eq("stall_wr_data", 64'(mif.wr_data), 64'(prev_data));
        check_eq("stall_rd_en", 64'(mif.rd_en), 64'(0));
      end
      if (mif.rd_en) begin
        if (rd_i > 0) begin
          lat_q.push_back(cyc - prev_rd_cyc);
          lst_q.push_back(lane_stalls);
        end
        prev_rd_cyc = cyc;
        lane_stalls = 0;
        if (rd_i < exp_rd.size()) check_eq("rd_addr", 64'(mif.rd_addr), 64'(exp_rd[rd_i]));
        rd_i++;
      end
      if (mif.wr_en) begin
        if (mif.wr_ready) begin
          if (wr_i < exp_wr.size()) check_eq("wr_addr", 64'(mif.wr_addr), 64'(exp_wr[wr_i]));
          wr_log.push_back(int'(mif.wr_addr));
          wr_i++;
          stall_run = 0;
        end else begin
          stalls++;
          lane_stalls++;
          stall_run++;
        end
      end
      prev_stall = mif.wr_en && !mif.wr_ready;
      prev_addr  = mif.wr_addr;
      prev_data  = mif.wr_data;
      if (done) begin
        done_cnt++;
        seen_done = 1;
        lat_q.push_back(cyc - prev_rd_cyc);
        lst_q.push_back(lane_stalls);
        check_eq("res_bank_at_done", 64'(res_bank), 64'(reff % 2));
      end
      start = (poke && (cyc == 12 || cyc == 40)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    mif.wr_ready = 1'b1;
    if (!seen_done) check_eq("timeout_waiting_done", 64'(0), 64'(1));
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      if (busy || mif.rd_en || mif.wr_en) extra++;
      @(negedge clk);
    end
    check_eq("done_pulses", 64'(done_cnt), 64'(1));
    check_eq("idle_after_done", 64'(extra), 64'(0));
    check_eq("res_bank_held", 64'(res_bank), 64'(reff % 2));
    check_eq("overlap", 64'(overlap), 64'(0));
    check_eq("read_count", 64'(rd_i), 64'(exp_rd.size()));
    check_eq("write_count", 64'(wr_i), 64'(exp_wr.size()));
    foreach (exp_k[i]) ksum += 5 + exp_k[i];
    check_eq("busy_cycles", 64'(busy_cnt), 64'(1 + ksum + stalls));
    check_eq("lat_count", 64'(lat_q.size()), 64'(exp_k.size()));
    for (int i = 0; i < lat_q.size() && i < exp_k.size(); i++)
      check_eq("lane_latency", 64'(lat_q[i]), 64'(5 + exp_k[i] + lst_q[i]));
    for (int i = 0; i < 2*NL; i++) check_eq("mem_data", mem[i], ref_mem[i]);
  endtask

  initial begin
    int bad = 0;
    mif.wr_ready = 1'b1;
    load_mem();
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_rd_en", 64'(mif.rd_en), 64'(0));
    check_eq("rst_wr_en", 64'(mif.wr_en), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Abort mid-REDUCE on the first lane
    coef_a = 3'd2; coef_b = 3'd3; num_rounds = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_done", 64'(done), 64'(0));
    check_eq("abort_res_bank", 64'(res_bank), 64'(0));
    check_eq("abort_rd_en", 64'(mif.rd_en), 64'(0));
    check_eq("abort_rd_addr", 64'(mif.rd_addr), 64'(0));
    check_eq("abort_wr_en", 64'(mif.wr_en), 64'(0));
    check_eq("abort_wr_addr", 64'(mif.wr_addr), 64'(0));
    check_eq("abort_wr_data", 64'(mif.wr_data), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || mif.rd_en || mif.wr_en) bad++;
    end
    check_eq("idle_no_strobes", 64'(bad), 64'(0));

    // Transpose, single round
    run_op(1, 0, 1, 0, 0);
    check_eq("transpose_busy", 64'(busy_cnt), 64'(126));

    // Pi step, single round, spot lanes
    run_op(2, 3, 1, 0, 0);
    if (wr_log.size() == NL && lat_q.size() == NL) begin
      check_eq("pi_lane1_wr", 64'(wr_log[1]), 64'(35));
      check_eq("pi_lane1_lat", 64'(lat_q[1]), 64'(5));
      check_eq("pi_lane6_wr", 64'(wr_log[6]), 64'(26));
      check_eq("pi_lane6_lat", 64'(lat_q[6]), 64'(6));
      check_eq("pi_lane24_wr", 64'(wr_log[24]), 64'(29));
      check_eq("pi_lane24_lat", 64'(lat_q[24]), 64'(9));
    end else begin
      check_eq("pi_log_size", 64'(wr_log.size()), 64'(NL));
    end

    // Three-cycle write stall on every lane
    run_op(2, 3, 1, 2, 0);

    // Two rounds with random stalls and stray start pulses
    run_op(2, 3, 2, 1, 1);

    // Zero rounds behaves as one
    run_op(2, 3, 0, 1, 0);

    // Random coefficients and round counts
    for (int t = 0; t < 3; t++)
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1, 1'(t));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
